ozpart_tile_sched: RTL and testbench

- Sequences the convolution address generator (Addr_FSM) across a run of tiles.
- Per tile it parks the generator in reset, loads the tile start address, pulses start, waits for done, then advances.
- Sits between the host/command layer and one Addr_FSM instance. Provides a valid/ready command handshake, abort, per-tile and run-complete pulses, a watchdog and an error flag.

---
 rtl/ozpart_sched_pkg.sv | 35 +++
 rtl/sched_watchdog.sv | 44 ++++
 rtl/ozpart_tile_sched.sv | 253 +++++++++++++++++++++++++
 tb/tb_ozpart_tile_sched.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ozpart_sched_pkg.sv
// ozpart_sched_pkg
// Shared types and default sizes for the Addr_FSM tile scheduler.
//   sched_state_t  : scheduler state encoding
//   *_DEF          : default parameter values for the scheduler and watchdog
//   ADDR_CNT_W     : width of the per-run address counter
package ozpart_sched_pkg;

    localparam int LIN_WIDTH_DEF = 10;
    localparam int TILE_W_DEF    = 8;
    localparam int TO_W_DEF      = 12;
    localparam int ADDR_CNT_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_LAUNCH,
        ST_RUN,
        ST_NEXT,
        ST_DRAIN,
        ST_FAULT
    } sched_state_t;

    // States in which a run is in progress.
    function automatic logic is_busy_state(input sched_state_t s);
        return (s == ST_CLR) || (s == ST_LAUNCH) || (s == ST_RUN) ||
               (s == ST_NEXT) || (s == ST_DRAIN);
    endfunction

    // States in which the generator is released from reset.
    function automatic logic is_gen_live_state(input sched_state_t s);
        return (s == ST_LAUNCH) || (s == ST_RUN) || (s == ST_NEXT) ||
               (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/sched_watchdog.sv
// sched_watchdog
// TO_W-bit up-counter that flags a tile which runs too long.
//   clk, res : clock, asynchronous active-low reset
//   clear    : force the count to zero (takes precedence over enable)
//   enable   : count this cycle; the counter sticks at its maximum
//   expired  : high in the enabled cycle whose increment reaches the maximum,
//              so a tile gets exactly 2^TO_W-1 RUN cycles before it is cut off
module sched_watchdog
    import ozpart_sched_pkg::*;
#(
    parameter int TO_W = TO_W_DEF
) (
    input  logic clk,
    input  logic res,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] CNT_MAX = '1;

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    assign expired = enable && !clear && (cnt_q == (CNT_MAX - TO_W'(1)));

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ozpart_tile_sched.sv
// ozpart_tile_sched
// Runs one Addr_FSM instance across a sequence of tiles. For each tile the
// generator is held in reset, given its start address, started, and watched
// until done; the start address then advances by the tile stride.
//   clk, res                  : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       : command handshake (base, stride, tile count)
//   abort                     : level request to cancel the current run
//   agen_res/start/start_addr : controls to the generator
//   agen_done/error/addr_valid: status from the generator
//   busy, tile_idx            : run in progress, index of the current tile
//   tile_done, all_done       : one-cycle completion pulses
//   err                       : sticky fault flag, cleared on the next accept
//   addr_cnt                  : saturating count of addr_valid cycles this run
// All outputs are registered.
module ozpart_tile_sched
    import ozpart_sched_pkg::*;
#(
    parameter int LIN_WIDTH    = LIN_WIDTH_DEF,
    parameter int TILE_W       = TILE_W_DEF,
    parameter int CLR_CYCLES   = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int TO_W         = TO_W_DEF
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LIN_WIDTH-1:0]  cmd_base_addr,
    input  logic [LIN_WIDTH-1:0]  cmd_tile_stride,
    input  logic [TILE_W-1:0]     cmd_tile_count,
    input  logic                  abort,
    output logic                  agen_res,
    output logic                  agen_start,
    output logic [LIN_WIDTH-1:0]  agen_start_addr,
    input  logic                  agen_done,
    input  logic                  agen_error,
    input  logic                  agen_addr_valid,
    output logic                  busy,
    output logic [TILE_W-1:0]     tile_idx,
    output logic                  tile_done,
    output logic                  all_done,
    output logic                  err,
    output logic [ADDR_CNT_W-1:0] addr_cnt
);

    // One phase counter serves both the CLR hold and the DRAIN window.
    localparam int PH_MAX = (CLR_CYCLES > DRAIN_CYCLES) ? CLR_CYCLES : DRAIN_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0] CLR_LAST   = PH_W'(CLR_CYCLES - 1);
    localparam logic [PH_W-1:0] DRAIN_LAST = PH_W'(DRAIN_CYCLES - 1);

    sched_state_t state_q, state_d;

    logic [PH_W-1:0]       ph_q, ph_d;
    logic [LIN_WIDTH-1:0]  stride_q, stride_d;
    logic [TILE_W-1:0]     count_q, count_d;
    logic [LIN_WIDTH-1:0]  start_addr_q, start_addr_d;
    logic [TILE_W-1:0]     tile_idx_q, tile_idx_d;
    logic                  err_q, err_d;
    logic [ADDR_CNT_W-1:0] addr_cnt_q, addr_cnt_d;
    logic                  tile_done_q, tile_done_d;
    logic                  all_done_q, all_done_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  agen_res_q, agen_res_d;
    logic                  agen_start_q, agen_start_d;
    logic                  busy_q, busy_d;

    logic                  accept;
    logic                  wd_clear;
    logic                  wd_enable;
    logic                  wd_expired;
    logic [LIN_WIDTH:0]    next_addr;

    sched_watchdog #(
        .TO_W (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .res     (res),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        stride_d     = stride_q;
        count_d      = count_q;
        start_addr_d = start_addr_q;
        tile_idx_d   = tile_idx_q;
        err_d        = err_q;
        addr_cnt_d   = addr_cnt_q;
        tile_done_d  = 1'b0;
        all_done_d   = 1'b0;
        accept       = 1'b0;
        wd_clear     = 1'b0;
        wd_enable    = 1'b0;

        // One extra bit so a carry out of the address space is visible.
        next_addr = {1'b0, start_addr_q} + {1'b0, stride_q};

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    accept       = 1'b1;
                    stride_d     = cmd_tile_stride;
                    count_d      = cmd_tile_count;
                    start_addr_d = cmd_base_addr;
                    tile_idx_d   = '0;
                    err_d        = 1'b0;
                    addr_cnt_d   = '0;
                    if (cmd_tile_count == '0) begin
                        // Empty run: report completion without touching the generator.
                        all_done_d = 1'b1;
                    end else begin
                        state_d = ST_CLR;
                        ph_d    = '0;
                    end
                end
            end

            ST_CLR: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (ph_q == CLR_LAST) begin
                    state_d = ST_LAUNCH;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end

            ST_LAUNCH: begin
                wd_clear = 1'b1;
                state_d  = abort ? ST_IDLE : ST_RUN;
            end

            ST_RUN: begin
                wd_enable = 1'b1;
                if (agen_addr_valid && (addr_cnt_q != '1)) begin
                    addr_cnt_d = addr_cnt_q + ADDR_CNT_W'(1);
                end
                // Generator error outranks abort, which outranks done and timeout.
                if (agen_error) begin
                    err_d   = 1'b1;
                    state_d = ST_FAULT;
                end else if (abort) begin
                    state_d = ST_DRAIN;
                    ph_d    = '0;
                end else if (agen_done) begin
                    tile_done_d = 1'b1;
                    state_d     = ST_NEXT;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_FAULT;
                end
            end

            ST_NEXT: begin
                if (abort) begin
                    state_d = ST_DRAIN;
                    ph_d    = '0;
                end else if (tile_idx_q == (count_q - TILE_W'(1))) begin
                    all_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (next_addr[LIN_WIDTH]) begin
                    // Never hand the generator a wrapped start address.
                    err_d   = 1'b1;
                    state_d = ST_FAULT;
                end else begin
                    tile_idx_d   = tile_idx_q + TILE_W'(1);
                    start_addr_d = next_addr[LIN_WIDTH-1:0];
                    state_d      = ST_CLR;
                    ph_d         = '0;
                end
            end

            ST_DRAIN: begin
                // Generator keeps running with start low so its valid
                // pipeline empties; addr_cnt is deliberately not updated.
                if (ph_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end

            ST_FAULT: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Control outputs are decoded from the next state so they are
        // registered yet line up with the state they belong to.
        cmd_ready_d  = (state_d == ST_IDLE) && !accept;
        agen_res_d   = is_gen_live_state(state_d);
        agen_start_d = (state_d == ST_LAUNCH);
        busy_d       = is_busy_state(state_d);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge regardless of block ordering.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q      <= ST_IDLE;
            ph_q         <= '0;
            stride_q     <= '0;
            count_q      <= '0;
            start_addr_q <= '0;
            tile_idx_q   <= '0;
            err_q        <= 1'b0;
            addr_cnt_q   <= '0;
            tile_done_q  <= 1'b0;
            all_done_q   <= 1'b0;
            cmd_ready_q  <= 1'b0;
            agen_res_q   <= 1'b0;
            agen_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            stride_q     <= stride_d;
            count_q      <= count_d;
            start_addr_q <= start_addr_d;
            tile_idx_q   <= tile_idx_d;
            err_q        <= err_d;
            addr_cnt_q   <= addr_cnt_d;
            tile_done_q  <= tile_done_d;
            all_done_q   <= all_done_d;
            cmd_ready_q  <= cmd_ready_d;
            agen_res_q   <= agen_res_d;
            agen_start_q <= agen_start_d;
            busy_q       <= busy_d;
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign agen_res        = agen_res_q;
    assign agen_start      = agen_start_q;
    assign agen_start_addr = start_addr_q;
    assign busy            = busy_q;
    assign tile_idx        = tile_idx_q;
    assign tile_done       = tile_done_q;
    assign all_done        = all_done_q;
    assign err             = err_q;
    assign addr_cnt        = addr_cnt_q;

endmodule

// File: tb/tb_ozpart_tile_sched.sv
// tb_ozpart_tile_sched
// Directed bench for ozpart_tile_sched with a small behavioural generator:
// after each start it raises addr_valid for 8 cycles and done 20 cycles later.
module tb_ozpart_tile_sched;

    localparam int LW      = 10;
    localparam int TW      = 8;
    localparam int CLR_N   = 2;
    localparam int DRAIN_N = 3;
    localparam int TB_TO_W = 6;
    localparam int TO_RUN  = (1 << TB_TO_W) - 1;

    logic          clk;
    logic          res;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [LW-1:0] cmd_base_addr;
    logic [LW-1:0] cmd_tile_stride;
    logic [TW-1:0] cmd_tile_count;
    logic          abort;
    logic          agen_res;
    logic          agen_start;
    logic [LW-1:0] agen_start_addr;
    logic          agen_done;
    logic          agen_error;
    logic          agen_addr_valid;
    logic          busy;
    logic [TW-1:0] tile_idx;
    logic          tile_done;
    logic          all_done;
    logic          err;
    logic [15:0]   addr_cnt;

    int errors = 0;
    int checks = 0;

    ozpart_tile_sched #(
        .LIN_WIDTH    (LW),
        .TILE_W       (TW),
        .CLR_CYCLES   (CLR_N),
        .DRAIN_CYCLES (DRAIN_N),
        .TO_W         (TB_TO_W)
    ) dut (
        .clk             (clk),
        .res             (res),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_base_addr   (cmd_base_addr),
        .cmd_tile_stride (cmd_tile_stride),
        .cmd_tile_count  (cmd_tile_count),
        .abort           (abort),
        .agen_res        (agen_res),
        .agen_start      (agen_start),
        .agen_start_addr (agen_start_addr),
        .agen_done       (agen_done),
        .agen_error      (agen_error),
        .agen_addr_valid (agen_addr_valid),
        .busy            (busy),
        .tile_idx        (tile_idx),
        .tile_done       (tile_done),
        .all_done        (all_done),
        .err             (err),
        .addr_cnt        (addr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generator model, updated on the falling edge.
    logic gen_run     = 1'b0;
    int   gen_cnt     = 0;
    logic gen_done_en = 1'b1;
    always @(negedge clk) begin
        if (!agen_res) begin
            gen_run = 1'b0;
            gen_cnt = 0;
        end else if (agen_start) begin
            gen_run = 1'b1;
            gen_cnt = 0;
        end else if (gen_run) begin
            gen_cnt++;
        end
        agen_addr_valid = gen_run && (gen_cnt >= 1) && (gen_cnt <= 8);
        agen_done       = gen_run && gen_done_en && (gen_cnt == 20);
    end

    // Event log: counts the cycle-long pulses as each cycle closes.
    int            n_start  = 0;
    int            n_tdone  = 0;
    int            n_adone  = 0;
    int            n_res_hi = 0;
    logic [LW-1:0] start_log [64];
    always @(posedge clk) begin
        if (agen_start) begin
            if (n_start < 64) start_log[n_start] = agen_start_addr;
            n_start++;
        end
        if (tile_done) n_tdone++;
        if (all_done)  n_adone++;
        if (agen_res)  n_res_hi++;
    end

    // Presents one command; returns on the falling edge after it is accepted.
    task automatic send_cmd(input logic [LW-1:0] base, input logic [LW-1:0] stride,
                            input logic [TW-1:0] count);
        int w;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid       = 1'b1;
        cmd_base_addr   = base;
        cmd_tile_stride = stride;
        cmd_tile_count  = count;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start();
        int w;
        w = 0;
        while (!agen_start && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!agen_start) begin
            checks++;
            errors++;
            $display("FAIL agen_start_wait: agen_start=%b required 1", agen_start);
        end
    endtask

    task automatic test_reset();
        res = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, agen_res, agen_start, busy, tile_done, all_done, err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {cmd_ready, agen_res, agen_start, busy, tile_done, all_done, err});
        end
        checks++;
        if (agen_start_addr !== '0 || tile_idx !== '0 || addr_cnt !== '0) begin
            errors++;
            $display("FAIL reset_values: addr=%h idx=%h cnt=%h required all 0",
                     agen_start_addr, tile_idx, addr_cnt);
        end
        res = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_three_tiles();
        int s0, t0, a0, lat, w;
        s0 = n_start; t0 = n_tdone; a0 = n_adone;
        send_cmd(10'h010, 10'h040, 8'd3);
        checks++;
        if ({busy, cmd_ready, agen_res} !== 3'b100 || agen_start_addr !== 10'h010) begin
            errors++;
            $display("FAIL accept_state: busy/ready/res=%b addr=%h required 100 010",
                     {busy, cmd_ready, agen_res}, agen_start_addr);
        end
        // Counted from the cycle in which the command handshake happened.
        lat = 1;
        while (!agen_start && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 1 + CLR_N) begin
            errors++;
            $display("FAIL accept_to_start: latency=%0d required %0d", lat, 1 + CLR_N);
        end
        w = 0;
        while (!tile_done && w < 100) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (tile_done !== 1'b1 || tile_idx !== 8'd0) begin
            errors++;
            $display("FAIL first_tile_done: tile_done=%b idx=%0d required 1 0", tile_done, tile_idx);
        end
        // tile_done shows one cycle after agen_done, so done-to-start is 2+CLR_N.
        lat = 0;
        while (!agen_start && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 1 + CLR_N || agen_start_addr !== 10'h050 || tile_idx !== 8'd1) begin
            errors++;
            $display("FAIL second_launch: latency=%0d addr=%h idx=%0d required %0d 050 1",
                     lat, agen_start_addr, tile_idx, 1 + CLR_N);
        end
        w = 0;
        while (!all_done && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (all_done !== 1'b1 || busy !== 1'b0 || tile_idx !== 8'd2) begin
            errors++;
            $display("FAIL run_complete: all_done=%b busy=%b idx=%0d required 1 0 2",
                     all_done, busy, tile_idx);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (n_start - s0 != 3 || start_log[s0] !== 10'h010 || start_log[s0+1] !== 10'h050 ||
            start_log[s0+2] !== 10'h090) begin
            errors++;
            $display("FAIL start_addrs: starts=%0d addrs=%h %h %h required 3 010 050 090",
                     n_start - s0, start_log[s0], start_log[s0+1], start_log[s0+2]);
        end
        checks++;
        if (n_tdone - t0 != 3 || n_adone - a0 != 1) begin
            errors++;
            $display("FAIL pulse_counts: tile_done=%0d all_done=%0d required 3 1",
                     n_tdone - t0, n_adone - a0);
        end
        checks++;
        if (addr_cnt !== 16'd24) begin
            errors++;
            $display("FAIL addr_cnt_run: got %0d required 24", addr_cnt);
        end
    endtask

    task automatic test_zero_count();
        int s0, a0, r0;
        s0 = n_start; a0 = n_adone; r0 = n_res_hi;
        send_cmd(10'h123, 10'h001, 8'd0);
        checks++;
        if ({all_done, busy, cmd_ready, agen_res} !== 4'b1000) begin
            errors++;
            $display("FAIL zero_accept: done/busy/ready/res=%b required 1000",
                     {all_done, busy, cmd_ready, agen_res});
        end
        @(negedge clk);
        checks++;
        if (all_done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_after: all_done=%b cmd_ready=%b required 0 1", all_done, cmd_ready);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (n_start != s0 || n_res_hi != r0 || n_adone - a0 != 1) begin
            errors++;
            $display("FAIL zero_no_launch: starts=%0d res_hi=%0d all_done=%0d required 0 0 1",
                     n_start - s0, n_res_hi - r0, n_adone - a0);
        end
    endtask

    task automatic test_carry();
        int s0, a0, w;
        s0 = n_start; a0 = n_adone;
        send_cmd(10'h3F0, 10'h020, 8'd2);
        w = 0;
        while (!tile_done && w < 100) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (tile_done !== 1'b1) begin
            errors++;
            $display("FAIL carry_tile0: tile_done=%b required 1", tile_done);
        end
        @(negedge clk);
        checks++;
        if ({err, busy, agen_res} !== 3'b100) begin
            errors++;
            $display("FAIL carry_fault: err/busy/res=%b required 100", {err, busy, agen_res});
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL carry_idle: cmd_ready=%b err=%b required 1 1", cmd_ready, err);
        end
        repeat (25) @(negedge clk);
        checks++;
        if (n_start - s0 != 1 || start_log[s0] !== 10'h3F0 || n_adone != a0 ||
            agen_start_addr !== 10'h3F0) begin
            errors++;
            $display("FAIL carry_no_wrap: starts=%0d first=%h all_done=%0d addr=%h required 1 3f0 0 3f0",
                     n_start - s0, start_log[s0], n_adone - a0, agen_start_addr);
        end
    endtask

    task automatic test_watchdog();
        int run;
        gen_done_en = 1'b0;
        send_cmd(10'h000, 10'h001, 8'd1);
        wait_start();
        run = 0;
        @(negedge clk);
        while (busy && run < 200) begin
            run++;
            @(negedge clk);
        end
        checks++;
        if (run != TO_RUN) begin
            errors++;
            $display("FAIL wd_run_cycles: got %0d required %0d", run, TO_RUN);
        end
        checks++;
        if (err !== 1'b1 || agen_res !== 1'b0 || addr_cnt !== 16'd8) begin
            errors++;
            $display("FAIL wd_fault: err=%b res=%b cnt=%0d required 1 0 8", err, agen_res, addr_cnt);
        end
        gen_done_en = 1'b1;
        send_cmd(10'h000, 10'h001, 8'd0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b required 0", err);
        end
    endtask

    task automatic test_priority();
        send_cmd(10'h200, 10'h010, 8'd1);
        wait_start();
        repeat (2) @(negedge clk);
        agen_error = 1'b1;
        abort      = 1'b1;
        @(negedge clk);
        agen_error = 1'b0;
        abort      = 1'b0;
        checks++;
        if ({err, busy, agen_res} !== 3'b100) begin
            errors++;
            $display("FAIL error_over_abort: err/busy/res=%b required 100", {err, busy, agen_res});
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort();
        int a0, t0, w;
        a0 = n_adone; t0 = n_tdone;
        send_cmd(10'h100, 10'h010, 8'd4);
        w = 0;
        while (!(agen_start && tile_idx == 8'd1) && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (agen_start !== 1'b1 || agen_start_addr !== 10'h110) begin
            errors++;
            $display("FAIL abort_tile1_launch: start=%b addr=%h required 1 110", agen_start, agen_start_addr);
        end
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < DRAIN_N; i++) begin
            checks++;
            if ({agen_res, agen_start, busy} !== 3'b101 || addr_cnt !== 16'd13) begin
                errors++;
                $display("FAIL drain_cycle%0d: res/start/busy=%b cnt=%0d required 101 13",
                         i, {agen_res, agen_start, busy}, addr_cnt);
            end
            @(negedge clk);
        end
        checks++;
        if ({busy, agen_res, cmd_ready} !== 3'b001 || tile_idx !== 8'd1) begin
            errors++;
            $display("FAIL abort_idle: busy/res/ready=%b idx=%0d required 001 1",
                     {busy, agen_res, cmd_ready}, tile_idx);
        end
        @(negedge clk);
        checks++;
        if (n_adone != a0 || n_tdone - t0 != 1) begin
            errors++;
            $display("FAIL abort_pulses: all_done=%0d tile_done=%0d required 0 1",
                     n_adone - a0, n_tdone - t0);
        end
    endtask

    task automatic test_async_reset();
        send_cmd(10'h040, 10'h040, 8'd2);
        wait_start();
        repeat (3) @(negedge clk);
        #2 res = 1'b0;
        #1;
        checks++;
        if ({agen_res, busy, cmd_ready} !== 3'b000 || agen_start_addr !== '0 ||
            tile_idx !== '0 || addr_cnt !== '0) begin
            errors++;
            $display("FAIL async_reset: res/busy/ready=%b addr=%h idx=%0d cnt=%0d required 000 0 0 0",
                     {agen_res, busy, cmd_ready}, agen_start_addr, tile_idx, addr_cnt);
        end
        repeat (2) @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_release: cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
        end
    endtask

    initial begin
        res             = 1'b0;
        cmd_valid       = 1'b0;
        cmd_base_addr   = '0;
        cmd_tile_stride = '0;
        cmd_tile_count  = '0;
        abort           = 1'b0;
        agen_error      = 1'b0;
        test_reset();
        test_three_tiles();
        test_zero_count();
        test_carry();
        test_watchdog();
        test_priority();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
